// File: rtl/mem_burst_pkg.sv
// Shared types and sizing helpers for the instruction-cache line-fill engine.
package mem_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int OFFSET_WIDTH_DEFAULT = 4;
    localparam int LINE_WORDS           = 1 << OFFSET_WIDTH_DEFAULT;

    // Number of words in a line for a given word-offset width.
    function automatic int line_words(input int offset_width);
        return 1 << offset_width;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth 1-bit shift register; aligns a RAM read strobe with its returning data.
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_bit,
    output logic o_tail
);

    logic [DEPTH-1:0] shift_q;
    logic [DEPTH-1:0] shift_d;

    // Shift the new strobe in at stage 0, each older stage moves one step toward the tail.
    always_comb begin
        shift_d    = shift_q;
        shift_d[0] = i_bit;
        for (int i = 1; i < DEPTH; i++) begin
            shift_d[i] = shift_q[i-1];
        end
    end

    // Pipeline register; reset discards any strobes still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign o_tail = shift_q[DEPTH-1];

endmodule

// File: rtl/mem_burst_reader.sv
// Line-fill engine: reads a whole cache line from the synchronous instruction RAM,
// word 0 upward, and streams it back as in-order valid/last beats.
module mem_burst_reader
    import mem_burst_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int OFFSET_WIDTH   = 4,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int READ_LATENCY   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req_valid,
    input  logic [ADDRESS_WIDTH-1:0]  i_req_address,
    output logic                      o_data_valid,
    output logic                      o_data_last,
    output logic [DATA_WIDTH-1:0]     o_data,
    output logic                      o_busy,
    output logic                      o_ram_en,
    output logic [RAM_ADDR_WIDTH-1:0] o_ram_addr,
    input  logic [DATA_WIDTH-1:0]     i_ram_data
);

    localparam int LINE_W = line_words(OFFSET_WIDTH);
    localparam int CNT_W  = OFFSET_WIDTH + 1;

    state_t                    state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] base_q, base_d;
    logic [CNT_W-1:0]          issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]          ret_cnt_q, ret_cnt_d;
    logic                      ram_en_q, ram_en_d;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                      data_valid_q, data_valid_d;
    logic                      data_last_q, data_last_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      busy_q, busy_d;
    logic                      beat_tail;

    // Address bits above the RAM port are meaningless to this engine.
    logic unused_req_high;
    assign unused_req_high = ^i_req_address[ADDRESS_WIDTH-1:RAM_ADDR_WIDTH];

    valid_delay_line #(
        .DEPTH (READ_LATENCY)
    ) u_strobe_delay (
        .clk    (clk),
        .rst_n  (rst),
        .i_bit  (ram_en_q),
        .o_tail (beat_tail)
    );

    // Next-state, counters and registered outputs. issue_cnt tracks the word index
    // currently presented on the RAM port, so the strobe for word 0 launches on the
    // same edge that leaves IDLE.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        issue_cnt_d  = issue_cnt_q;
        ret_cnt_d    = ret_cnt_q;
        ram_en_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        data_valid_d = 1'b0;
        data_last_d  = 1'b0;
        data_d       = data_q;

        // A strobe reaching the pipeline tail means RAM data is valid now.
        if (beat_tail) begin
            data_d       = i_ram_data;
            data_valid_d = 1'b1;
            data_last_d  = (ret_cnt_q == CNT_W'(LINE_W - 1));
            ret_cnt_d    = ret_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    base_d      = {i_req_address[RAM_ADDR_WIDTH-1:OFFSET_WIDTH],
                                   {OFFSET_WIDTH{1'b0}}};
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                issue_cnt_d = issue_cnt_q + 1'b1;
                if (issue_cnt_d == CNT_W'(LINE_W)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave once the final beat has been presented to the cache.
                if (data_last_q) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Absorbs the cache's still-asserted request for one cycle.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == ISSUE) begin
            ram_en_d   = 1'b1;
            ram_addr_d = base_d | RAM_ADDR_WIDTH'(issue_cnt_d[OFFSET_WIDTH-1:0]);
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any burst in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            issue_cnt_q  <= '0;
            ret_cnt_q    <= '0;
            ram_en_q     <= 1'b0;
            ram_addr_q   <= '0;
            data_valid_q <= 1'b0;
            data_last_q  <= 1'b0;
            data_q       <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            issue_cnt_q  <= issue_cnt_d;
            ret_cnt_q    <= ret_cnt_d;
            ram_en_q     <= ram_en_d;
            ram_addr_q   <= ram_addr_d;
            data_valid_q <= data_valid_d;
            data_last_q  <= data_last_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
        end
    end

    assign o_data_valid = data_valid_q;
    assign o_data_last  = data_last_q;
    assign o_data       = data_q;
    assign o_busy       = busy_q;
    assign o_ram_en     = ram_en_q;
    assign o_ram_addr   = ram_addr_q;

endmodule
